// File: rtl/pex8311_lbus_pkg.sv
// Shared constants for the PEX8311 C-mode local-bus target: FSM state
// encoding, the read data returned when an access times out, and the
// default timeout length.
package pex8311_lbus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RDY  = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  localparam logic [31:0] LBUS_TMO_DATA        = 32'hDEAD_BEEF;
  localparam int          LBUS_TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/pex8311_lbus_tmo.sv
// Access timeout counter. Cleared on every entry into the request state,
// counts while the request is outstanding, and flags expiry during the
// TIMEOUT_CYC-th request cycle so the sequencer can abandon the access on
// that same edge.
module pex8311_lbus_tmo
  import pex8311_lbus_pkg::*;
#(
  parameter int TIMEOUT_CYC = LBUS_TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expire = run && (cnt == CW'(TIMEOUT_CYC - 1));

  // Count request cycles; restart on request entry, hold once expired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run && !expire) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pex8311_lbus_target.sv
// PEX8311 C-mode local-bus target sequencer.
// Turns PEX8311 master cycles (ADS_N / BLAST_N / LWR) into a single
// outstanding REG_REQ/REG_ACK handshake and paces every data beat with one
// READY_N low cycle.
// Write data is sampled on the same edge that raises REG_REQ (the ADS edge
// for the first beat, the READY edge for later beats), so REG_WDATA is
// already stable when an ACK arrives in the first request cycle.
// Optional feature: define PEX8311_LBUS_TIMEOUT_EN to abandon an access whose
// REG_ACK has not arrived within TIMEOUT_CYC request cycles.
module pex8311_lbus_target
  import pex8311_lbus_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = LBUS_TIMEOUT_CYC_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              LRESET_N,
  input  logic [31:0]       LA,
  input  logic [31:0]       LD_I,
  output logic [31:0]       LD_O,
  output logic              LD_OE,
  input  logic [3:0]        LBE_N,
  input  logic              ADS_N,
  input  logic              BLAST_N,
  input  logic              LWR,
  output logic              READY_N,
  output logic              REG_REQ,
  output logic              REG_WE,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [31:0]       REG_WDATA,
  output logic [3:0]        REG_BE,
  input  logic              REG_ACK,
  input  logic [31:0]       REG_RDATA,
  output logic              ERR_ADS,
  output logic              TMO_ERR
);

  logic [1:0] state;
  logic       tmo_expire;

  // Only the word-address bits of LA are decoded.
  logic unused_la;
  assign unused_la = ^{LA[31:ADDR_W+2], LA[1:0]};

`ifdef PEX8311_LBUS_TIMEOUT_EN
  logic tmo_load;
  logic tmo_run;

  // The counter restarts whenever a new request is about to be raised.
  assign tmo_load = ((state == ST_IDLE) && !ADS_N) || ((state == ST_RDY) && BLAST_N);
  assign tmo_run  = (state == ST_REQ);

  pex8311_lbus_tmo #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk    (CLK),
    .rst_n  (nRST),
    .load   (tmo_load),
    .run    (tmo_run),
    .expire (tmo_expire)
  );
`else
  logic [31:0] unused_tmo_cyc;
  assign unused_tmo_cyc = 32'(TIMEOUT_CYC);
  assign tmo_expire     = 1'b0;
`endif

  // Bus sequencer: IDLE -> REQ -> RDY -> (REQ for next beat | TURN) -> IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      LD_O      <= 32'h0000_0000;
      LD_OE     <= 1'b0;
      READY_N   <= 1'b1;
      REG_REQ   <= 1'b0;
      REG_WE    <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= 32'h0000_0000;
      REG_BE    <= 4'h0;
      ERR_ADS   <= 1'b0;
      TMO_ERR   <= 1'b0;
    end else if (!LRESET_N) begin
      // Local reset abandons whatever is in flight; a late ACK is then
      // ignored because IDLE never looks at REG_ACK.
      state   <= ST_IDLE;
      LD_OE   <= 1'b0;
      READY_N <= 1'b1;
      REG_REQ <= 1'b0;
      ERR_ADS <= 1'b0;
      TMO_ERR <= 1'b0;
    end else begin
      ERR_ADS <= !ADS_N && (state != ST_IDLE);
      TMO_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!ADS_N) begin
            state    <= ST_REQ;
            REG_REQ  <= 1'b1;
            REG_WE   <= LWR;
            REG_ADDR <= LA[ADDR_W+1:2];
            REG_BE   <= ~LBE_N;
            if (LWR) begin
              REG_WDATA <= LD_I;
            end else begin
              REG_WDATA <= REG_WDATA;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (REG_ACK) begin
            state   <= ST_RDY;
            REG_REQ <= 1'b0;
            READY_N <= 1'b0;
            LD_OE   <= !REG_WE;
            if (!REG_WE) begin
              LD_O <= REG_RDATA;
            end else begin
              LD_O <= LD_O;
            end
          end else if (tmo_expire) begin
            state   <= ST_RDY;
            REG_REQ <= 1'b0;
            READY_N <= 1'b0;
            LD_OE   <= !REG_WE;
            TMO_ERR <= 1'b1;
            if (!REG_WE) begin
              LD_O <= LBUS_TMO_DATA;
            end else begin
              LD_O <= LD_O;
            end
          end else begin
            state <= ST_REQ;
          end
        end
        ST_RDY: begin
          READY_N <= 1'b1;
          LD_OE   <= 1'b0;
          if (!BLAST_N) begin
            state <= ST_TURN;
          end else begin
            // Burst continues at the next word; the address wraps naturally.
            state    <= ST_REQ;
            REG_REQ  <= 1'b1;
            REG_ADDR <= REG_ADDR + ADDR_W'(1);
            REG_BE   <= ~LBE_N;
            if (REG_WE) begin
              REG_WDATA <= LD_I;
            end else begin
              REG_WDATA <= REG_WDATA;
            end
          end
        end
        ST_TURN: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          REG_REQ <= 1'b0;
          READY_N <= 1'b1;
          LD_OE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pex8311_lbus_target.sv
// Self-checking bench for pex8311_lbus_target (ADDR_W=8, TIMEOUT_CYC=8).
// Inputs are driven and outputs sampled on the falling clock edge. The
// expected behaviour comes from a transaction-level view of the bus: word
// address = LA/4 plus the beat index modulo 256, byte enables are the
// inverted LBE_N of each beat, READY arrives one cycle after the ACK, and
// global event counters tally READY, ERR_ADS and TMO_ERR pulses.
module tb_pex8311_lbus_target;

  localparam int ADDR_W = 8;
  localparam int TMO    = 8;

  logic              CLK;
  logic              nRST;
  logic              LRESET_N;
  logic [31:0]       LA;
  logic [31:0]       LD_I;
  logic [31:0]       LD_O;
  logic              LD_OE;
  logic [3:0]        LBE_N;
  logic              ADS_N;
  logic              BLAST_N;
  logic              LWR;
  logic              READY_N;
  logic              REG_REQ;
  logic              REG_WE;
  logic [ADDR_W-1:0] REG_ADDR;
  logic [31:0]       REG_WDATA;
  logic [3:0]        REG_BE;
  logic              REG_ACK;
  logic [31:0]       REG_RDATA;
  logic              ERR_ADS;
  logic              TMO_ERR;

  int vectors    = 0;
  int miscompares = 0;
  int ready_cnt  = 0;
  int err_cnt    = 0;
  int tmo_cnt    = 0;
  int oe_wr_cnt  = 0;
  logic cur_we   = 1'b0;

  pex8311_lbus_target #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .LRESET_N  (LRESET_N),
    .LA        (LA),
    .LD_I      (LD_I),
    .LD_O      (LD_O),
    .LD_OE     (LD_OE),
    .LBE_N     (LBE_N),
    .ADS_N     (ADS_N),
    .BLAST_N   (BLAST_N),
    .LWR       (LWR),
    .READY_N   (READY_N),
    .REG_REQ   (REG_REQ),
    .REG_WE    (REG_WE),
    .REG_ADDR  (REG_ADDR),
    .REG_WDATA (REG_WDATA),
    .REG_BE    (REG_BE),
    .REG_ACK   (REG_ACK),
    .REG_RDATA (REG_RDATA),
    .ERR_ADS   (ERR_ADS),
    .TMO_ERR   (TMO_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event tallies sampled mid-cycle.
  always @(negedge CLK) begin
    if (nRST) begin
      if (!READY_N) ready_cnt = ready_cnt + 1;
      if (ERR_ADS)  err_cnt   = err_cnt + 1;
      if (TMO_ERR)  tmo_cnt   = tmo_cnt + 1;
      if (LD_OE && cur_we) oe_wr_cnt = oe_wr_cnt + 1;
    end
  end

  // Runs one burst as the PEX8311 master and the register responder.
  task automatic run_burst(input logic we, input logic [31:0] la, input int nb,
                           input int dmin, input int dmax, input logic [3:0] be_n0,
                           input logic [31:0] wd0, input logic [31:0] rd0, input bit inject);
    logic [ADDR_W-1:0] exp_addr;
    logic [3:0]        be_n;
    logic [31:0]       wd;
    logic [31:0]       rd;
    int                dly;
    exp_addr = la[ADDR_W+1:2];
    be_n = be_n0; wd = wd0; rd = rd0;
    cur_we = we;
    @(negedge CLK);
    ADS_N = 1'b0; LA = la; LWR = we; LBE_N = be_n; LD_I = wd;
    BLAST_N = (nb == 1) ? 1'b0 : 1'b1;
    for (int b = 0; b < nb; b++) begin
      dly = $urandom_range(dmax, dmin);
      @(negedge CLK);
      if (inject && b == 0) begin
        ADS_N = 1'b0; LA = ~la; LWR = ~we;
      end else begin
        ADS_N = 1'b1;
      end
      vectors++;
      if ({REG_REQ, REG_WE, REG_ADDR, REG_BE, READY_N} !== {1'b1, we, exp_addr, ~be_n, 1'b1}) begin
        miscompares++;
        $display("FAIL req_fields beat %0d: got req=%b we=%b addr=%h be=%h rdy_n=%b, want req=1 we=%b addr=%h be=%h rdy_n=1",
                 b, REG_REQ, REG_WE, REG_ADDR, REG_BE, READY_N, we, exp_addr, ~be_n);
      end
      if (we) begin
        vectors++;
        if (REG_WDATA !== wd) begin
          miscompares++;
          $display("FAIL wdata beat %0d: got %h want %h", b, REG_WDATA, wd);
        end
      end
      for (int c = 0; c < dly; c++) begin
        @(negedge CLK);
        ADS_N = 1'b1;
        vectors++;
        if ({REG_REQ, READY_N, REG_ADDR, REG_WE} !== {1'b1, 1'b1, exp_addr, we}) begin
          miscompares++;
          $display("FAIL req_hold beat %0d wait %0d: got req=%b rdy_n=%b addr=%h we=%b, want 1 1 %h %b",
                   b, c, REG_REQ, READY_N, REG_ADDR, REG_WE, exp_addr, we);
        end
      end
      REG_ACK = 1'b1; REG_RDATA = rd;
      @(negedge CLK);
      ADS_N = 1'b1; REG_ACK = 1'b0; REG_RDATA = $urandom;
      vectors++;
      if ({READY_N, REG_REQ, LD_OE} !== {1'b0, 1'b0, ~we}) begin
        miscompares++;
        $display("FAIL ready_beat %0d: got rdy_n=%b req=%b oe=%b, want 0 0 %b", b, READY_N, REG_REQ, LD_OE, ~we);
      end
      if (!we) begin
        vectors++;
        if (LD_O !== rd) begin
          miscompares++;
          $display("FAIL rdata beat %0d: got %h want %h", b, LD_O, rd);
        end
      end
      BLAST_N  = (b == nb - 1) ? 1'b0 : 1'b1;
      exp_addr = exp_addr + ADDR_W'(1);
      be_n = 4'($urandom_range(15, 0)); wd = $urandom; rd = $urandom;
      LBE_N = be_n; LD_I = wd;
    end
    @(negedge CLK);
    vectors++;
    if ({READY_N, REG_REQ, LD_OE} !== 3'b100) begin
      miscompares++;
      $display("FAIL turn: got rdy_n=%b req=%b oe=%b, want 1 0 0", READY_N, REG_REQ, LD_OE);
    end
    BLAST_N = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({READY_N, REG_REQ, LD_OE} !== 3'b100) begin
      miscompares++;
      $display("FAIL idle: got rdy_n=%b req=%b oe=%b, want 1 0 0", READY_N, REG_REQ, LD_OE);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; LRESET_N = 1'b1; LA = 32'h0; LD_I = 32'h0; LBE_N = 4'hF;
    ADS_N = 1'b1; BLAST_N = 1'b1; LWR = 1'b0; REG_ACK = 1'b0; REG_RDATA = 32'h0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({LD_O, LD_OE, READY_N} !== {32'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_ld: got ld_o=%h oe=%b rdy_n=%b, want 0 0 1", LD_O, LD_OE, READY_N);
    end
    vectors++;
    if ({REG_REQ, REG_WE, REG_ADDR, REG_WDATA, REG_BE} !== {1'b0, 1'b0, 8'h00, 32'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_reg: got req=%b we=%b addr=%h wd=%h be=%h, want all 0",
               REG_REQ, REG_WE, REG_ADDR, REG_WDATA, REG_BE);
    end
    vectors++;
    if ({ERR_ADS, TMO_ERR} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_err: got err_ads=%b tmo_err=%b, want 0 0", ERR_ADS, TMO_ERR);
    end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_write();
    int r0;
    r0 = ready_cnt;
    run_burst(1'b1, 32'h0000_0010, 1, 1, 1, 4'h0, 32'h1234_5678, 32'h0, 1'b0);
    vectors++;
    if (ready_cnt - r0 !== 1) begin
      miscompares++;
      $display("FAIL write_ready_count: got %0d want 1", ready_cnt - r0);
    end
    vectors++;
    if (oe_wr_cnt !== 0) begin
      miscompares++;
      $display("FAIL write_oe: LD_OE high %0d cycles during writes, want 0", oe_wr_cnt);
    end
  endtask

  task automatic test_single_read();
    int r0;
    r0 = ready_cnt;
    run_burst(1'b0, 32'h0000_0020, 1, 0, 0, 4'h0, 32'h0, 32'hCAFE_0001, 1'b0);
    vectors++;
    if (ready_cnt - r0 !== 1) begin
      miscompares++;
      $display("FAIL read_ready_count: got %0d want 1", ready_cnt - r0);
    end
  endtask

  task automatic test_wrap_burst();
    int r0;
    r0 = ready_cnt;
    run_burst(1'b0, 32'h0000_03F8, 4, 0, 2, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0);
    vectors++;
    if (ready_cnt - r0 !== 4) begin
      miscompares++;
      $display("FAIL wrap_ready_count: got %0d want 4", ready_cnt - r0);
    end
  endtask

`ifdef PEX8311_LBUS_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    int req_cycles;
    logic [31:0] rd;
    t0 = tmo_cnt;
    cur_we = 1'b0;
    @(negedge CLK);
    ADS_N = 1'b0; LA = 32'h0000_0100; LWR = 1'b0; LBE_N = 4'h0; BLAST_N = 1'b0;
    req_cycles = 0;
    for (int c = 0; c < TMO + 4; c++) begin
      @(negedge CLK);
      ADS_N = 1'b1;
      if (REG_REQ) req_cycles++;
      else break;
    end
    vectors++;
    if (req_cycles !== TMO) begin
      miscompares++;
      $display("FAIL tmo_req_cycles: got %0d want %0d", req_cycles, TMO);
    end
    vectors++;
    if ({READY_N, TMO_ERR, LD_O} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL tmo_expire: got rdy_n=%b tmo=%b ld_o=%h, want 0 1 deadbeef", READY_N, TMO_ERR, LD_O);
    end
    repeat (2) @(negedge CLK);
    BLAST_N = 1'b1;
    // ACK arriving in the expiry cycle completes normally.
    rd = $urandom;
    @(negedge CLK);
    ADS_N = 1'b0; LA = 32'h0000_0104; BLAST_N = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      @(negedge CLK);
      ADS_N = 1'b1;
      vectors++;
      if (REG_REQ !== 1'b1) begin
        miscompares++;
        $display("FAIL tmo_ack_wait cycle %0d: req=%b want 1", c, REG_REQ);
      end
    end
    REG_ACK = 1'b1; REG_RDATA = rd;
    @(negedge CLK);
    REG_ACK = 1'b0;
    vectors++;
    if ({READY_N, TMO_ERR, LD_O} !== {1'b0, 1'b0, rd}) begin
      miscompares++;
      $display("FAIL tmo_ack_wins: got rdy_n=%b tmo=%b ld_o=%h, want 0 0 %h", READY_N, TMO_ERR, LD_O, rd);
    end
    repeat (2) @(negedge CLK);
    BLAST_N = 1'b1;
    vectors++;
    if (tmo_cnt - t0 !== 1) begin
      miscompares++;
      $display("FAIL tmo_pulse_count: got %0d want 1", tmo_cnt - t0);
    end
  endtask
`else
  task automatic test_timeout();
    logic [31:0] rd;
    rd = $urandom;
    cur_we = 1'b0;
    @(negedge CLK);
    ADS_N = 1'b0; LA = 32'h0000_0100; LWR = 1'b0; LBE_N = 4'h0; BLAST_N = 1'b0;
    for (int c = 0; c < 3 * TMO; c++) begin
      @(negedge CLK);
      ADS_N = 1'b1;
      vectors++;
      if ({REG_REQ, READY_N, TMO_ERR} !== 3'b110) begin
        miscompares++;
        $display("FAIL no_tmo_wait cycle %0d: got req=%b rdy_n=%b tmo=%b, want 1 1 0", c, REG_REQ, READY_N, TMO_ERR);
      end
    end
    REG_ACK = 1'b1; REG_RDATA = rd;
    @(negedge CLK);
    REG_ACK = 1'b0;
    vectors++;
    if ({READY_N, LD_O} !== {1'b0, rd}) begin
      miscompares++;
      $display("FAIL no_tmo_complete: got rdy_n=%b ld_o=%h, want 0 %h", READY_N, LD_O, rd);
    end
    repeat (2) @(negedge CLK);
    BLAST_N = 1'b1;
    vectors++;
    if (tmo_cnt !== 0) begin
      miscompares++;
      $display("FAIL no_tmo_pulses: got %0d want 0", tmo_cnt);
    end
  endtask
`endif

  task automatic test_lreset_abort();
    cur_we = 1'b1;
    @(negedge CLK);
    ADS_N = 1'b0; LA = 32'h0000_0040; LWR = 1'b1; LBE_N = 4'h0; LD_I = 32'h1111_1111; BLAST_N = 1'b1;
    @(negedge CLK);
    ADS_N = 1'b1;
    REG_ACK = 1'b1; REG_RDATA = 32'h0;
    @(negedge CLK);
    REG_ACK = 1'b0;
    vectors++;
    if (READY_N !== 1'b0) begin
      miscompares++;
      $display("FAIL lrst_beat1_ready: got %b want 0", READY_N);
    end
    LD_I = 32'h2222_2222;
    @(negedge CLK);
    vectors++;
    if ({REG_REQ, REG_ADDR, REG_WDATA} !== {1'b1, 8'h11, 32'h2222_2222}) begin
      miscompares++;
      $display("FAIL lrst_beat2_req: got req=%b addr=%h wd=%h, want 1 11 22222222", REG_REQ, REG_ADDR, REG_WDATA);
    end
    LRESET_N = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({REG_REQ, READY_N, LD_OE} !== 3'b010) begin
      miscompares++;
      $display("FAIL lrst_abort: got req=%b rdy_n=%b oe=%b, want 0 1 0", REG_REQ, READY_N, LD_OE);
    end
    LRESET_N = 1'b1; REG_ACK = 1'b1;
    @(negedge CLK);
    REG_ACK = 1'b0;
    vectors++;
    if ({REG_REQ, READY_N} !== 2'b01) begin
      miscompares++;
      $display("FAIL lrst_late_ack: got req=%b rdy_n=%b, want 0 1", REG_REQ, READY_N);
    end
    run_burst(1'b0, 32'h0000_0080, 1, 0, 1, 4'h5, 32'h0, 32'h5A5A_1234, 1'b0);
  endtask

  task automatic test_ads_error();
    int e0;
    e0 = err_cnt;
    run_burst(1'b0, 32'h0000_0044, 1, 2, 3, 4'h3, 32'h0, 32'hA5A5_0F0F, 1'b1);
    vectors++;
    if (err_cnt - e0 !== 1) begin
      miscompares++;
      $display("FAIL ads_err_pulses: got %0d want 1", err_cnt - e0);
    end
  endtask

  task automatic test_random_bursts();
    int r0;
    int e0;
    int beats;
    int nb;
    r0 = ready_cnt; e0 = err_cnt; beats = 0;
    for (int i = 0; i < 20; i++) begin
      nb = $urandom_range(4, 1);
      beats += nb;
      run_burst(1'($urandom_range(1, 0)), $urandom, nb, 0, 3,
                4'($urandom_range(15, 0)), $urandom, $urandom, 1'b0);
    end
    vectors++;
    if (ready_cnt - r0 !== beats) begin
      miscompares++;
      $display("FAIL rand_ready_count: got %0d want %0d", ready_cnt - r0, beats);
    end
    vectors++;
    if (err_cnt - e0 !== 0) begin
      miscompares++;
      $display("FAIL rand_err_ads: got %0d want 0", err_cnt - e0);
    end
    vectors++;
    if (oe_wr_cnt !== 0) begin
      miscompares++;
      $display("FAIL rand_write_oe: LD_OE high %0d cycles during writes, want 0", oe_wr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_wrap_burst();
    test_timeout();
    test_lreset_abort();
    test_ads_error();
    test_random_bursts();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
